// File: rtl/irq_pending_arbiter.sv
// Synchronizes eight request lines, latches them as pending bits and offers the
// highest-priority unmasked one as a 3-bit ID (code = 7 - index) over valid/ready.
module irq_pending_arbiter #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  output logic [2:0] id_out,
  output logic       id_valid,
  input  logic       id_ready,
  output logic [7:0] pending
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] s2_d;
  logic [7:0] set_bits;
  logic [7:0] clr;
  logic [7:0] eligible;
  logic [7:0] pending_next;
  logic [2:0] id_next;

  // Ascending scan so the highest set index is the one that sticks.
  function automatic logic [2:0] winner_code(input logic [7:0] v);
    winner_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) winner_code = 3'(7 - i);
    end
  endfunction

  function automatic logic [7:0] code_onehot(input logic [2:0] code);
    code_onehot = 8'b1000_0000 >> code;
  endfunction

  // Synchronizer stage plus delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 8'h00;
      s2   <= 8'h00;
      s2_d <= 8'h00;
    end else begin
      s1   <= req;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign set_bits     = EDGE_MODE ? (s2 & ~s2_d) : s2;
  assign eligible     = pending & ~mask;
  assign pending_next = (pending & ~clr) | set_bits;
  assign id_valid     = (state == OFFER);

  always_comb begin
    state_next = state;
    id_next    = id_out;
    clr        = 8'h00;
    case (state)
      IDLE: begin
        if (|eligible) begin
          id_next    = winner_code(eligible);
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (id_ready) begin
          clr        = code_onehot(id_out);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending / offer register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      id_out  <= 3'b000;
      pending <= 8'h00;
    end else begin
      state   <= state_next;
      id_out  <= id_next;
      pending <= pending_next;
    end
  end

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Scoreboard bench for irq_pending_arbiter: directed scenarios plus random traffic
// against a cycle-level reference model of the pending/offer behaviour.
module tb_irq_pending_arbiter;

  localparam bit EDGE = 1'b1;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic [2:0] id_out;
  logic       id_valid;
  logic       id_ready;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;

  irq_pending_arbiter #(.EDGE_MODE(EDGE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .mask     (mask),
    .id_out   (id_out),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .pending  (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: req history as a 3-deep delay line, pending as a bit set,
  // and a single outstanding offer (present flag + code).
  bit [7:0] hist [3];
  bit [7:0] m_pend;
  bit       m_offer;
  int       m_code;
  int       exp_q [$];

  always @(posedge clk or negedge rst_n) begin
    bit [7:0] set_v;
    bit [7:0] clr_v;
    bit [7:0] elig;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) hist[i] = 8'h00;
      m_pend  = 8'h00;
      m_offer = 1'b0;
      m_code  = 0;
      exp_q.delete();
    end else begin
      set_v = EDGE ? (hist[1] & ~hist[2]) : hist[1];
      clr_v = 8'h00;
      if (m_offer) begin
        if (id_ready) begin
          clr_v[7 - m_code] = 1'b1;
          m_offer = 1'b0;
        end
      end else begin
        elig = m_pend & ~mask;
        for (int i = 7; i >= 0; i--) begin
          if (elig[i]) begin
            m_code  = 7 - i;
            m_offer = 1'b1;
            exp_q.push_back(m_code);
            break;
          end
        end
      end
      m_pend  = (m_pend & ~clr_v) | set_v;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = req;
    end
  end

  // Monitor: status every cycle, offered ID popped from the scoreboard on each new offer.
  bit mon_prev = 1'b0;
  int held     = 0;

  always @(negedge clk) begin
    check("pending", int'(pending), int'(m_pend));
    check("id_valid", int'(id_valid), int'(m_offer));
    if (id_valid && !mon_prev) begin
      if (exp_q.size() == 0) begin
        check("offer_unexpected", int'(id_out), -1);
      end else begin
        held = exp_q.pop_front();
        check("offer_id", int'(id_out), held);
      end
    end else if (id_valid) begin
      check("offer_hold", int'(id_out), held);
    end
    mon_prev = id_valid;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] m, input logic rdy);
    req      = r;
    mask     = m;
    id_ready = rdy;
  endtask

  task automatic quiet();
    drive(8'h00, 8'h00, 1'b1);
    repeat (8) tick();
  endtask

  initial begin
    rst_n = 1'b1;
    drive(8'h00, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("reset_valid", int'(id_valid), 0);
    check("reset_pending", int'(pending), 0);
    check("reset_id", int'(id_out), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_reset_valid", int'(id_valid), 0);

    // Single edge latency on req[5]
    drive(8'h20, 8'h00, 1'b1);
    tick(); check("lat_k_pending", int'(pending), 8'h00);
    tick(); check("lat_k1_pending", int'(pending), 8'h00);
    tick(); check("lat_k2_pending", int'(pending), 8'h20);
    drive(8'h00, 8'h00, 1'b1);
    tick(); check("lat_k3_valid", int'(id_valid), 1); check("lat_k3_id", int'(id_out), 3'b010);
    tick(); check("lat_k4_pending", int'(pending), 8'h00); check("lat_k4_valid", int'(id_valid), 0);
    quiet();

    // Priority and pacing
    drive(8'h81, 8'h00, 1'b1);
    repeat (3) tick();
    check("prio_pending", int'(pending), 8'h81);
    drive(8'h00, 8'h00, 1'b1);
    tick(); check("prio_first", int'(id_out), 3'b000); check("prio_first_v", int'(id_valid), 1);
    tick(); check("prio_gap_v", int'(id_valid), 0); check("prio_gap_pend", int'(pending), 8'h01);
    tick(); check("prio_second", int'(id_out), 3'b111); check("prio_second_v", int'(id_valid), 1);
    tick(); check("prio_end_pend", int'(pending), 8'h00);
    quiet();

    // Backpressure with mask and higher request arriving mid-offer
    drive(8'h40, 8'h00, 1'b0);
    repeat (3) tick();
    drive(8'h00, 8'h00, 1'b0);
    tick(); check("bp_offer", int'(id_out), 3'b001);
    drive(8'h80, 8'h40, 1'b0);
    repeat (4) tick();
    check("bp_hold_id", int'(id_out), 3'b001);
    check("bp_hold_v", int'(id_valid), 1);
    check("bp_pend", int'(pending), 8'hC0);
    drive(8'h00, 8'h00, 1'b1);
    tick(); check("bp_hs_v", int'(id_valid), 0);
    tick(); check("bp_next", int'(id_out), 3'b000); check("bp_next_v", int'(id_valid), 1);
    quiet();

    // Masked hold
    drive(8'h01, 8'hFF, 1'b1);
    repeat (3) tick();
    drive(8'h00, 8'hFF, 1'b1);
    repeat (3) tick();
    check("mask_pend", int'(pending), 8'h01);
    check("mask_no_offer", int'(id_valid), 0);
    drive(8'h00, 8'h00, 1'b1);
    tick(); check("unmask_offer", int'(id_out), 3'b111); check("unmask_v", int'(id_valid), 1);
    quiet();

    // Set wins over clear on the same bit
    drive(8'h08, 8'h00, 1'b0);
    repeat (3) tick();
    drive(8'h00, 8'h00, 1'b0);
    tick(); check("coll_offer", int'(id_out), 3'b100);
    repeat (3) tick();
    drive(8'h08, 8'h00, 1'b0);
    tick();
    tick();
    drive(8'h08, 8'h00, 1'b1);
    tick(); check("coll_pend", int'(pending), 8'h08); check("coll_gap_v", int'(id_valid), 0);
    drive(8'h00, 8'h00, 1'b1);
    tick(); check("coll_reoffer", int'(id_out), 3'b100); check("coll_reoffer_v", int'(id_valid), 1);
    quiet();

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      tick();
      req      = 8'($urandom & $urandom & $urandom);
      id_ready = ($urandom_range(0, 3) != 0);
      if (c % 64 == 0) mask = 8'($urandom & $urandom);
    end
    quiet();

    // Reset asserted mid-offer
    begin
      int n = 0;
      drive(8'h10, 8'h00, 1'b0);
      while (!id_valid && n < 20) begin
        tick();
        n++;
      end
      check("rst_offer_seen", int'(id_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_valid", int'(id_valid), 0);
      check("rst_mid_id", int'(id_out), 0);
      check("rst_mid_pend", int'(pending), 0);
      tick();
      drive(8'h00, 8'h00, 1'b1);
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("rst_rel_valid", int'(id_valid), 0);
      check("rst_rel_pend", int'(pending), 0);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_pending_arbiter.md
# irq_pending_arbiter

Front end that collects eight asynchronous request lines, latches them as pending bits, applies a mask, and offers the highest-priority unmasked request as a 3-bit ID over a valid/ready handshake. It sits directly upstream of the 8-to-3 priority encoding stage and replaces its raw one-hot input with a registered, arbitrated, handshaked ID stream. It uses the same code mapping as that stage: bit 7 → 3'b000 … bit 0 → 3'b111, so code = 7 − index.

## Interface
- EDGE_MODE, 1, 1 = a rising edge on the synchronized request sets pending; 0 = level mode, pending is set every cycle the synchronized request is high.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  8  asynchronous request lines; bit 7 has the highest priority.
- mask  in  8  synchronous; 1 blocks that bit from selection but does not stop it being latched.
- id_out  out  3  offered ID, registered; code = 7 − winning index.
- id_valid  out  1  offer present, registered.
- id_ready  in  1  consumer accepts the offer when id_valid && id_ready at a rising clk edge.
- pending  out  8  pending register, visible for status.

## Operation
- Synchronizer: two flops per bit, s1 then s2, plus delayed copy s2_d for edge detect. All three reset to 0.
- Set term:
  - EDGE_MODE=1: set[i] = s2[i] & ~s2_d[i].
  - EDGE_MODE=0: set[i] = s2[i].
- Pending update each cycle: pending_next = (pending & ~clr) | set. Set wins over clear on the same bit in the same cycle.
- clr is one-hot at the bit named by id_out when a handshake occurs, else 0.
- Eligible = pending & ~mask. The winner is the highest set index of eligible.
- FSM, two states:
  - IDLE: id_valid=0. If eligible≠0, register id_out = 7 − winner, go to OFFER. Otherwise stay.
  - OFFER: id_valid=1; id_out and id_valid are held stable. Changes to mask or pending do not retract or alter the offer. On id_valid && id_ready: clear that pending bit and go to IDLE.
- Throughput: at most one grant every 2 cycles, because IDLE is always visited between offers.
- Masked pending bits stay pending indefinitely. Unmasking makes them eligible on the next IDLE evaluation.
- A repeated edge on an already-pending bit merges with it; no count is kept.

## Timing
- Reset (rst_n=0, asynchronous): s1, s2, s2_d, pending = 8'h00; id_out = 3'b000; id_valid = 0; state = IDLE.
- Reset mid-offer: the offer drops immediately and all pending bits are lost.
- A req line held high through reset release shows as a rising edge after reset, because s2_d resets to 0.
- Latency: req stable high before edge k:
  - s1 = 1 after edge k;
  - s2 = 1 after edge k+1;
  - pending set after edge k+2;
  - id_valid = 1 after edge k+3 (assuming IDLE and unmasked).
- id_ready may be high before id_valid. The handshake then completes on the first edge with id_valid=1, i.e. the offer lasts exactly one cycle.
- After a handshake at edge t: id_valid = 0 after t. The next offer, if eligible≠0, has id_valid = 1 after edge t+1.
- Level mode: a line still high after its grant re-sets pending in the same cycle the handshake clears it, so it is offered again.
- Outputs change only on clk edges or asynchronous reset. There are no combinational paths from inputs to outputs.

## Test plan
- Reset values: assert rst_n=0 mid-OFFER -> id_valid=0, id_out=000, pending=00 immediately, without a clock edge. Release rst_n with req=00 -> no offer.
- Single edge latency (EDGE_MODE=1, id_ready=1): pulse req[5] for 3 cycles -> pending=8'h20 after edge k+2, id_valid=1 with id_out=3'b010 after edge k+3, pending=00 after edge k+4.
- Priority and pacing: set req=8'h81 together, id_ready=1 -> offers 000 then 111, two cycles apart; pending ends 00.
- Backpressure and mask: req[6], id_ready=0, then raise mask[6] and req[7] during OFFER -> id_out stays 001. Drop mask and raise id_ready -> handshake, then 000 is offered.
- Masked hold: mask=8'hFF, pulse req[0] -> pending=8'h01 and id_valid stays 0. Clear mask -> id_out=111.
- Set-wins collision: new edge on req[3] lands in the same cycle its offer (id_out=100) is accepted -> pending[3] stays 1 and is re-offered.
